cla_flow_ptr_alloc: RTL and testbench
=====================================

# cla_flow_ptr_alloc

Pointer-allocation front end for the classifier flow table. It sits directly downstream of `cla_flow_free_list`. It turns flow-create requests into free-list pops and returns the popped pointer. It screens flow-delete requests against an in-use bitmap before releasing pointers back to the free list. It also sequences free-list re-initialisation and tracks the live flow count.

## Interface
- `BPTR_NBITS`, default `FLOW_VALUE_DEPTH_NBITS`: flow pointer width; the pool is 2^BPTR_NBITS entries.
- `STALL_MAX`, default 8: maximum number of cycles an allocation may wait on an empty free list before it is refused.

One clock; reset is synchronous and active-high. Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flow_init` in 1: pulse; requests table re-initialisation.
- `alloc_req` in 1: level; held by the requester until `alloc_ack` or `alloc_nack`.
- `alloc_ack` out 1: pulse; allocation succeeded.
- `alloc_nack` out 1: pulse; allocation refused.
- `alloc_ptr` out BPTR_NBITS: allocated pointer; valid with `alloc_ack`.
- `dealloc_valid` in 1: pulse; release request.
- `dealloc_ptr` in BPTR_NBITS: pointer to release.
- `dealloc_err` out 1: pulse; release dropped because the pointer was not in use.
- `inuse_count` out BPTR_NBITS+1: number of live pointers.
- `alloc_rdy` out 1: high in RUN.
- `freeb_init` out 1: to the free list.
- `freeb_init_done` in 1: from the free list.
- `freeb_empty` in 1: from the free list.
- `free_buf_ptr` in BPTR_NBITS: free-list head (first-word fall-through).
- `free_buf_rd` out 1: free-list pop.
- `rel_buf_valid` out 1: release strobe to the free list.
- `rel_buf_ptr` out BPTR_NBITS: pointer being released.

## Operation
State machine, with transitions:
- WAIT_INIT → RUN when `freeb_init_done`=1.
- RUN → REINIT on `flow_init`.
- REINIT → WAIT_INIT when `freeb_init_done`=0.
- After reset the state is WAIT_INIT.

Re-initialisation:
- `freeb_init` is a one-cycle registered pulse issued on the RUN→REINIT transition.
- `flow_init` outside RUN is ignored.
- Entering REINIT clears the bitmap, `inuse_count` and `stall_cnt`.

Allocation (RUN only):
- The block samples `alloc_req` in every cycle in which neither `alloc_ack` nor `alloc_nack` is high.
- If `freeb_empty`=0, `free_buf_rd`=1 combinationally in that cycle. The following cycle drives `alloc_ack`=1 and `alloc_ptr`=`free_buf_ptr` (registered), sets bitmap[ptr] and increments `inuse_count`.
- If `freeb_empty`=1, `stall_cnt` increments. When the request is sampled with `stall_cnt`==STALL_MAX-1 and the list is still empty, `alloc_nack`=1 next cycle and `stall_cnt` clears.
- `stall_cnt` also clears on every `alloc_ack`.
- `alloc_req` sampled high outside RUN, or on the `flow_init` cycle, produces `alloc_nack` next cycle with no pop.
- `free_buf_rd` is never asserted unless state=RUN and `freeb_init_done`=1.

Release:
- When `dealloc_valid`=1 in RUN and bitmap[`dealloc_ptr`]=1, the next cycle drives `rel_buf_valid`=1 and `rel_buf_ptr`=`dealloc_ptr`, clears the bit and decrements `inuse_count`.
- When bitmap[`dealloc_ptr`]=0, `dealloc_err`=1 next cycle and no release is issued.
- Outside RUN, releases are dropped silently: no `dealloc_err`.
- Throughput is one release per cycle.

Simultaneous events:
- An ack and a valid release in the same cycle leave `inuse_count` unchanged.
- The release check uses the bitmap before that cycle's allocation update. A pointer popped at cycle t cannot be released before t+2; an earlier attempt raises `dealloc_err`.

Arithmetic: `inuse_count` saturates at 2^BPTR_NBITS and at 0. It cannot wrap under legal traffic.

## Timing
- Reset values: all outputs 0; bitmap cleared; `stall_cnt`=0; state WAIT_INIT.
- Alloc latency: `alloc_ack` or `alloc_nack` arrives 1 cycle after the sampling cycle. Maximum allocation rate is one per 2 cycles.
- Empty-list refusal: first empty-sampled cycle at t gives `alloc_nack` at t+STALL_MAX.
- Release latency: 1 cycle, from `dealloc_valid` to `rel_buf_valid` or `dealloc_err`.
- Re-init: `freeb_init` appears 1 cycle after `flow_init`. `alloc_rdy` drops in the same cycle as `freeb_init` and returns 1 cycle after `freeb_init_done` re-asserts.
- Reset mid-operation: an outstanding ack or release is lost; the requester must re-request.

## Structure
- Shared package `cla_pkg` holds:
  - the state encodings WAIT_INIT=0, RUN=1, REINIT=2;
  - the `FLOW_VALUE_DEPTH_NBITS` default.
- Sub-module: `cla_flow_inuse_bitmap`, a 2^BPTR_NBITS-bit register array. It has one set port and one clear port, a combinational read, and a synchronous clear-all.

## Test plan
- Reset, then `freeb_init_done` rises at cycle 5 → `alloc_rdy`=1 at cycle 6. `alloc_req` held with `free_buf_ptr`=3 → `free_buf_rd` pulse, then `alloc_ack` with `alloc_ptr`=3 and `inuse_count`=1.
- Allocate pointer 3, then `dealloc_ptr`=3 → `rel_buf_valid` with `rel_buf_ptr`=3 next cycle and `inuse_count`=0. Repeat `dealloc_ptr`=3 → `dealloc_err`=1 and no release.
- `freeb_empty` held at 1 with `alloc_req` high, STALL_MAX=8 → `alloc_nack` exactly 8 cycles later and `free_buf_rd` never asserted. Repeat with `freeb_empty` dropping at cycle 4 → `alloc_ack` instead.
- Same cycle: an alloc of pointer 5 acks while pointer 2 (live) is released → `inuse_count` unchanged, bit 5 set, bit 2 clear.
- `flow_init` pulse with 4 live pointers and `alloc_req` high → `freeb_init` pulse, `alloc_nack`, `inuse_count`=0. A `dealloc_valid` during REINIT is dropped with no `dealloc_err`. RUN re-entered after `freeb_init_done` toggles 0→1.
- Back-to-back: 16 allocations on BPTR_NBITS=4 → pointers returned in free-list order, one every 2 cycles, `inuse_count`=16.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared classifier constants: default flow pointer width and allocator state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cla_pkg;

   localparam int FLOW_VALUE_DEPTH_NBITS = 4;

   // Allocator state encodings, kept as plain constants for legacy tooling.
   localparam logic [1:0] WAIT_INIT = 2'd0;
   localparam logic [1:0] RUN       = 2'd1;
   localparam logic [1:0] REINIT    = 2'd2;

endpackage

// File: rtl/cla_flow_ptr_alloc_if.sv
// Allocator handshake bundle: create/delete requests plus the free-list side.
// Latency: wires only.
// Backpressure: alloc_req is held until alloc_ack/alloc_nack; releases are never backpressured.
interface cla_flow_ptr_alloc_if
   import cla_pkg::*;
#(
   parameter int BPTR_NBITS = FLOW_VALUE_DEPTH_NBITS
);
   logic                  flow_init;
   logic                  alloc_req;
   logic                  alloc_ack;
   logic                  alloc_nack;
   logic [BPTR_NBITS-1:0] alloc_ptr;
   logic                  dealloc_valid;
   logic [BPTR_NBITS-1:0] dealloc_ptr;
   logic                  dealloc_err;
   logic [BPTR_NBITS:0]   inuse_count;
   logic                  alloc_rdy;
   logic                  freeb_init;
   logic                  freeb_init_done;
   logic                  freeb_empty;
   logic [BPTR_NBITS-1:0] free_buf_ptr;
   logic                  free_buf_rd;
   logic                  rel_buf_valid;
   logic [BPTR_NBITS-1:0] rel_buf_ptr;

   // Allocator side.
   modport slave (
      input  flow_init, alloc_req, dealloc_valid, dealloc_ptr,
      input  freeb_init_done, freeb_empty, free_buf_ptr,
      output alloc_ack, alloc_nack, alloc_ptr, dealloc_err, inuse_count, alloc_rdy,
      output freeb_init, free_buf_rd, rel_buf_valid, rel_buf_ptr
   );

   // Requester / free-list side.
   modport master (
      output flow_init, alloc_req, dealloc_valid, dealloc_ptr,
      output freeb_init_done, freeb_empty, free_buf_ptr,
      input  alloc_ack, alloc_nack, alloc_ptr, dealloc_err, inuse_count, alloc_rdy,
      input  freeb_init, free_buf_rd, rel_buf_valid, rel_buf_ptr
   );

endinterface

// File: rtl/cla_flow_inuse_bitmap.sv
// One bit per flow pointer marking it live; one set port, one clear port, combinational read.
// Latency: set/clear visible the cycle after the write; read is combinational.
// Backpressure: none, accepts one set and one clear every cycle.
module cla_flow_inuse_bitmap
   import cla_pkg::*;
#(
   parameter int BPTR_NBITS = FLOW_VALUE_DEPTH_NBITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_all,
   input  logic                  set_en,
   input  logic [BPTR_NBITS-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [BPTR_NBITS-1:0] clr_idx,
   input  logic [BPTR_NBITS-1:0] rd_idx,
   output logic                  rd_bit
);
   localparam int DEPTH = 1 << BPTR_NBITS;

   logic [DEPTH-1:0] bits;

   // Bulk clear wins over any single-bit update issued in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || clr_all) begin
         bits <= '0;
      end else begin
         if (set_en) bits[set_idx] <= 1'b1;
         if (clr_en) bits[clr_idx] <= 1'b0;
      end
   end

   assign rd_bit = bits[rd_idx];

endmodule

// File: rtl/cla_flow_ptr_alloc.sv
// Flow pointer allocator: create requests pop the free list, deletes are screened by an in-use bitmap.
// Latency: ack/nack 1 cycle after the sampled request; release/err 1 cycle after dealloc_valid.
// Backpressure: a request waits on an empty free list for up to STALL_MAX cycles, then is nacked.
module cla_flow_ptr_alloc
   import cla_pkg::*;
#(
   parameter int BPTR_NBITS = FLOW_VALUE_DEPTH_NBITS,
   parameter int STALL_MAX  = 8
) (
   input  logic                clk,
   input  logic                rst,
   cla_flow_ptr_alloc_if.slave bus
);
   localparam int                  SC_NBITS = $clog2(STALL_MAX + 1);
   localparam logic [BPTR_NBITS:0] CNT_MAX  = {1'b1, {BPTR_NBITS{1'b0}}};

   logic [1:0]          state;
   logic [SC_NBITS-1:0] stall_cnt;
   logic                in_run;
   logic                reinit_go;
   logic                sample;
   logic                pop;
   logic                stall_go;
   logic                stall_last;
   logic                nack_nxt;
   logic                inuse_bit;
   logic                rel_ok;

   assign in_run     = (state == RUN);
   assign reinit_go  = in_run && bus.flow_init;
   // A held request is ignored while its response is on the wire so it is never served twice.
   assign sample     = bus.alloc_req && !bus.alloc_ack && !bus.alloc_nack;
   assign pop        = sample && in_run && !bus.flow_init && bus.freeb_init_done && !bus.freeb_empty;
   assign stall_go   = sample && in_run && !bus.flow_init && !pop;
   assign stall_last = (stall_cnt == SC_NBITS'(STALL_MAX - 1));
   assign nack_nxt   = sample && (!in_run || bus.flow_init || (stall_go && stall_last));
   assign rel_ok     = bus.dealloc_valid && in_run && inuse_bit;

   assign bus.free_buf_rd = pop;
   assign bus.alloc_rdy   = in_run;

   // Init handshake with the free list: wait for done, run, then drop back while it re-initialises.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WAIT_INIT;
      end else begin
         case (state)
            WAIT_INIT: if (bus.freeb_init_done)  state <= RUN;
            RUN:       if (bus.flow_init)        state <= REINIT;
            REINIT:    if (!bus.freeb_init_done) state <= WAIT_INIT;
            default:                             state <= WAIT_INIT;
         endcase
      end
   end

   // Allocation response, captured head pointer, empty-list stall timer and init pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.alloc_ack  <= 1'b0;
         bus.alloc_nack <= 1'b0;
         bus.alloc_ptr  <= '0;
         bus.freeb_init <= 1'b0;
         stall_cnt      <= '0;
      end else begin
         bus.alloc_ack  <= pop;
         bus.alloc_nack <= nack_nxt;
         bus.freeb_init <= reinit_go;
         if (pop) bus.alloc_ptr <= bus.free_buf_ptr;
         if (reinit_go || pop || bus.alloc_ack) begin
            stall_cnt <= '0;
         end else if (stall_go) begin
            stall_cnt <= stall_last ? '0 : stall_cnt + 1'b1;
         end
      end
   end

   // Release path: forward live pointers to the free list, flag pointers that are not live.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rel_buf_valid <= 1'b0;
         bus.rel_buf_ptr   <= '0;
         bus.dealloc_err   <= 1'b0;
      end else begin
         bus.rel_buf_valid <= rel_ok;
         bus.dealloc_err   <= bus.dealloc_valid && in_run && !inuse_bit;
         if (rel_ok) bus.rel_buf_ptr <= bus.dealloc_ptr;
      end
   end

   // Live count follows the bitmap: +1 on the ack cycle, -1 on an accepted release, saturating.
   always_ff @(posedge clk) begin
      if (rst || reinit_go) begin
         bus.inuse_count <= '0;
      end else if (bus.alloc_ack && !rel_ok) begin
         if (bus.inuse_count != CNT_MAX) bus.inuse_count <= bus.inuse_count + 1'b1;
      end else if (rel_ok && !bus.alloc_ack) begin
         if (bus.inuse_count != '0) bus.inuse_count <= bus.inuse_count - 1'b1;
      end
   end

   // The bit is set at the end of the ack cycle, so a release attempted during the ack
   // cycle still sees the pointer as free and is refused.
   cla_flow_inuse_bitmap #(
      .BPTR_NBITS (BPTR_NBITS)
   ) u_bitmap (
      .clk     (clk),
      .rst     (rst),
      .clr_all (reinit_go),
      .set_en  (bus.alloc_ack),
      .set_idx (bus.alloc_ptr),
      .clr_en  (rel_ok),
      .clr_idx (bus.dealloc_ptr),
      .rd_idx  (bus.dealloc_ptr),
      .rd_bit  (inuse_bit)
   );

endmodule

// File: tb/tb_cla_flow_ptr_alloc.sv
// Bench for the flow pointer allocator: vector table for the basic flow, hand sequences for corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_cla_flow_ptr_alloc;
   import cla_pkg::*;

   localparam int BP = 4;
   localparam int NV = 17;

   typedef struct {
      int fi, req, dv, dp, done, emp, fbp;
      int rdy, rd, ack, nack, aptr, rv, rptr, err, cnt, finit;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   vec_t vt [NV];
   int   order [16];

   cla_flow_ptr_alloc_if #(.BPTR_NBITS(BP)) bus ();

   cla_flow_ptr_alloc #(
      .BPTR_NBITS (BP),
      .STALL_MAX  (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int fi, int req, int dv, int dp, int done, int emp, int fbp,
                               int rdy, int rd, int ack, int nack, int aptr, int rv, int rptr,
                               int err, int cnt, int finit);
      return '{fi, req, dv, dp, done, emp, fbp, rdy, rd, ack, nack, aptr, rv, rptr, err, cnt, finit};
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d: got %0h, want %0h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      bus.flow_init       = 1'(v.fi);
      bus.alloc_req       = 1'(v.req);
      bus.dealloc_valid   = 1'(v.dv);
      bus.dealloc_ptr     = BP'(v.dp);
      bus.freeb_init_done = 1'(v.done);
      bus.freeb_empty     = 1'(v.emp);
      bus.free_buf_ptr    = BP'(v.fbp);
   endtask

   task automatic check_outputs(input int idx, input vec_t v);
      chk("alloc_rdy",     idx, 32'(bus.alloc_rdy),     32'(v.rdy));
      chk("free_buf_rd",   idx, 32'(bus.free_buf_rd),   32'(v.rd));
      chk("alloc_ack",     idx, 32'(bus.alloc_ack),     32'(v.ack));
      chk("alloc_nack",    idx, 32'(bus.alloc_nack),    32'(v.nack));
      chk("alloc_ptr",     idx, 32'(bus.alloc_ptr),     32'(v.aptr));
      chk("rel_buf_valid", idx, 32'(bus.rel_buf_valid), 32'(v.rv));
      chk("rel_buf_ptr",   idx, 32'(bus.rel_buf_ptr),   32'(v.rptr));
      chk("dealloc_err",   idx, 32'(bus.dealloc_err),   32'(v.err));
      chk("inuse_count",   idx, 32'(bus.inuse_count),   32'(v.cnt));
      chk("freeb_init",    idx, 32'(bus.freeb_init),    32'(v.finit));
   endtask

   // Holds alloc_req with the given free-list head until ack, expecting a 1-cycle response.
   task automatic do_alloc(input int ptr);
      int   n;
      logic got;
      tick();
      bus.alloc_req    = 1'b1;
      bus.freeb_empty  = 1'b0;
      bus.free_buf_ptr = BP'(ptr);
      #1;
      chk("alloc_pop", ptr, 32'(bus.free_buf_rd), 32'd1);
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         tick();
         n++;
         got = bus.alloc_ack;
      end
      chk("alloc_latency", ptr, n, 1);
      chk("alloc_ptr_val", ptr, 32'(bus.alloc_ptr), 32'(ptr));
      bus.alloc_req = 1'b0;
   endtask

   // One-cycle release pulse; checks the response in the following cycle.
   task automatic do_dealloc(input int ptr, input int exp_rel);
      tick();
      bus.dealloc_valid = 1'b1;
      bus.dealloc_ptr   = BP'(ptr);
      #1;
      tick();
      bus.dealloc_valid = 1'b0;
      #1;
      chk("rel_valid", ptr, 32'(bus.rel_buf_valid), 32'(exp_rel));
      chk("rel_err",   ptr, 32'(bus.dealloc_err),   32'(1 - exp_rel));
      if (exp_rel != 0) chk("rel_ptr", ptr, 32'(bus.rel_buf_ptr), 32'(ptr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int t_nack, rd_seen, idx, acks, last;

      //                 fi req dv dp dn em fbp  rdy rd ack nak apt rv rpt err cnt fin
      vt[0]  = mk(0, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[1]  = mk(0, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[2]  = mk(0, 0, 1, 3, 0, 0, 3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[3]  = mk(0, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[4]  = mk(0, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[5]  = mk(0, 0, 0, 0, 1, 0, 3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[6]  = mk(0, 1, 0, 0, 1, 0, 3,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[7]  = mk(0, 1, 0, 0, 1, 0, 7,   1, 0, 1, 0, 3, 0, 0, 0, 0, 0);
      vt[8]  = mk(0, 0, 0, 0, 1, 0, 7,   1, 0, 0, 0, 3, 0, 0, 0, 1, 0);
      vt[9]  = mk(0, 0, 1, 3, 1, 0, 7,   1, 0, 0, 0, 3, 0, 0, 0, 1, 0);
      vt[10] = mk(0, 0, 1, 3, 1, 0, 7,   1, 0, 0, 0, 3, 1, 3, 0, 0, 0);
      vt[11] = mk(0, 0, 0, 0, 1, 0, 7,   1, 0, 0, 0, 3, 0, 3, 1, 0, 0);
      vt[12] = mk(0, 0, 0, 0, 1, 0, 7,   1, 0, 0, 0, 3, 0, 3, 0, 0, 0);
      vt[13] = mk(0, 1, 0, 0, 1, 0, 7,   1, 1, 0, 0, 3, 0, 3, 0, 0, 0);
      vt[14] = mk(0, 1, 1, 7, 1, 0, 9,   1, 0, 1, 0, 7, 0, 3, 0, 0, 0);
      vt[15] = mk(0, 0, 1, 7, 1, 0, 9,   1, 0, 0, 0, 7, 0, 3, 1, 1, 0);
      vt[16] = mk(0, 0, 0, 0, 1, 0, 9,   1, 0, 0, 0, 7, 1, 7, 0, 0, 0);

      for (int i = 0; i < 16; i++) order[i] = (i * 5 + 3) % 16;

      rst = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (3) tick();
      check_outputs(-1, mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Bring-up, first allocation, release, double release, release on the ack cycle.
      for (int i = 0; i < NV; i++) begin
         tick();
         rst = 1'b0;
         apply(vt[i]);
         #1;
         check_outputs(i, vt[i]);
      end

      // Empty free list held: nack exactly 8 cycles after the first sampled cycle, no pop.
      do_alloc(2);
      tick();
      bus.alloc_req    = 1'b1;
      bus.freeb_empty  = 1'b1;
      bus.free_buf_ptr = BP'(6);
      #1;
      t_nack  = -1;
      rd_seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.free_buf_rd) rd_seen++;
         if (bus.alloc_nack) begin
            t_nack = k;
            break;
         end
         tick();
      end
      bus.alloc_req = 1'b0;
      chk("stall_nack_cycle", 0, t_nack, 8);
      chk("stall_no_pop", 0, rd_seen, 0);
      chk("stall_count_kept", 0, 32'(bus.inuse_count), 32'd1);

      // Empty list clears at cycle 4: pop then ack with pointer 5 while live pointer 2 is released.
      tick();
      bus.alloc_req    = 1'b1;
      bus.freeb_empty  = 1'b1;
      bus.free_buf_ptr = BP'(5);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("late_no_pop", k, 32'(bus.free_buf_rd), 32'd0);
         tick();
      end
      bus.freeb_empty = 1'b0;
      #1;
      chk("late_pop", 0, 32'(bus.free_buf_rd), 32'd1);
      chk("late_no_nack", 0, 32'(bus.alloc_nack), 32'd0);
      tick();
      chk("late_ack", 0, 32'(bus.alloc_ack), 32'd1);
      chk("late_ptr", 0, 32'(bus.alloc_ptr), 32'd5);
      bus.alloc_req     = 1'b0;
      bus.dealloc_valid = 1'b1;
      bus.dealloc_ptr   = BP'(2);
      #1;
      tick();
      bus.dealloc_valid = 1'b0;
      #1;
      chk("simul_rel_valid", 0, 32'(bus.rel_buf_valid), 32'd1);
      chk("simul_rel_ptr", 0, 32'(bus.rel_buf_ptr), 32'd2);
      chk("simul_count", 0, 32'(bus.inuse_count), 32'd1);
      do_dealloc(2, 0);
      chk("bit2_clear_count", 0, 32'(bus.inuse_count), 32'd1);
      do_dealloc(5, 1);
      chk("bit5_set_count", 0, 32'(bus.inuse_count), 32'd0);

      // Re-initialisation with four live pointers and a request pending.
      do_alloc(1);
      do_alloc(4);
      do_alloc(9);
      do_alloc(12);
      tick();
      chk("live_four", 0, 32'(bus.inuse_count), 32'd4);
      bus.flow_init    = 1'b1;
      bus.alloc_req    = 1'b1;
      bus.freeb_empty  = 1'b0;
      bus.free_buf_ptr = BP'(6);
      #1;
      chk("init_no_pop", 0, 32'(bus.free_buf_rd), 32'd0);
      tick();
      bus.flow_init     = 1'b0;
      bus.dealloc_valid = 1'b1;
      bus.dealloc_ptr   = BP'(1);
      #1;
      chk("init_pulse", 0, 32'(bus.freeb_init), 32'd1);
      chk("init_nack", 0, 32'(bus.alloc_nack), 32'd1);
      chk("init_rdy_low", 0, 32'(bus.alloc_rdy), 32'd0);
      chk("init_count", 0, 32'(bus.inuse_count), 32'd0);
      chk("init_no_ack", 0, 32'(bus.alloc_ack), 32'd0);
      tick();
      bus.alloc_req       = 1'b0;
      bus.dealloc_valid   = 1'b0;
      bus.freeb_init_done = 1'b0;
      #1;
      chk("init_pulse_end", 0, 32'(bus.freeb_init), 32'd0);
      chk("reinit_no_err", 0, 32'(bus.dealloc_err), 32'd0);
      chk("reinit_no_rel", 0, 32'(bus.rel_buf_valid), 32'd0);
      tick();
      bus.alloc_req = 1'b1;
      #1;
      chk("wait_rdy_low", 0, 32'(bus.alloc_rdy), 32'd0);
      chk("wait_no_pop", 0, 32'(bus.free_buf_rd), 32'd0);
      tick();
      chk("wait_nack", 0, 32'(bus.alloc_nack), 32'd1);
      bus.alloc_req = 1'b0;
      tick();
      bus.freeb_init_done = 1'b1;
      #1;
      chk("done_rdy_low", 0, 32'(bus.alloc_rdy), 32'd0);
      tick();
      chk("rerun_rdy", 0, 32'(bus.alloc_rdy), 32'd1);
      do_dealloc(1, 0);
      chk("cleared_count", 0, 32'(bus.inuse_count), 32'd0);

      // Sixteen back-to-back allocations, request held continuously.
      idx  = 0;
      acks = 0;
      last = -1;
      tick();
      bus.alloc_req    = 1'b1;
      bus.freeb_empty  = 1'b0;
      bus.free_buf_ptr = BP'(order[0]);
      #1;
      for (int c = 0; c < 60; c++) begin
         if (bus.alloc_ack) begin
            chk("b2b_ptr", acks, 32'(bus.alloc_ptr), 32'(order[acks]));
            if (acks > 0) chk("b2b_gap", acks, c - last, 2);
            last = c;
            acks++;
            if (acks == 16) bus.alloc_req = 1'b0;
         end
         if (bus.free_buf_rd) idx++;
         if (acks == 16) break;
         tick();
         bus.freeb_empty  = (idx >= 16);
         bus.free_buf_ptr = BP'(order[idx % 16]);
         #1;
      end
      chk("b2b_acks", 0, acks, 16);
      tick();
      chk("b2b_count", 0, 32'(bus.inuse_count), 32'd16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
